// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage.
// Covers opcode encodings, instruction classes and the slot payloads.
package decode_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned RIDX_W   = 5;
  localparam int unsigned LINK_REG = 31;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BC    = 6'b110010;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_IALU    = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_JUMP    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] cmd;
  } fetch_word_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    instr_class_e      cls;
    logic [RIDX_W-1:0] rs;
    logic [RIDX_W-1:0] rt;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   imm;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [5:0]        op;
  } dec_instr_t;

endpackage

// File: rtl/decode_if.sv
// Decode-to-execute issue bus: valid/ready handshake plus decoded fields.
interface decode_if;
  import decode_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [2:0]        out_class;
  logic [RIDX_W-1:0] out_rs;
  logic [RIDX_W-1:0] out_rt;
  logic [RIDX_W-1:0] out_rd;
  logic [XLEN-1:0]   out_imm;
  logic [4:0]        out_shamt;
  logic [5:0]        out_funct;
  logic [5:0]        out_op;

  modport master (
    output out_valid, out_pc, out_class, out_rs, out_rt, out_rd,
           out_imm, out_shamt, out_funct, out_op,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_class, out_rs, out_rt, out_rd,
           out_imm, out_shamt, out_funct, out_op,
    output out_ready
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard with same-cycle writeback bypass and
// a RAW hazard query against both busy registers and the occupied out slot.
module decode_scoreboard
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [RIDX_W-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [RIDX_W-1:0] clr_idx_i,
  input  logic [RIDX_W-1:0] rs_i,
  input  logic [RIDX_W-1:0] rt_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  input  logic              pend_en_i,
  input  logic [RIDX_W-1:0] pend_rd_i,
  output logic              hazard_c_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            rs_haz;
  logic            rt_haz;

  // A retiring writeback to a source hides its busy bit in the same cycle.
  always_comb begin
    rs_haz = use_rs_i && (rs_i != '0) &&
             ((busy_q[rs_i] && !(clr_en_i && (clr_idx_i == rs_i))) ||
              (pend_en_i && (pend_rd_i == rs_i)));
    rt_haz = use_rt_i && (rt_i != '0) &&
             ((busy_q[rt_i] && !(clr_en_i && (clr_idx_i == rt_i))) ||
              (pend_en_i && (pend_rd_i == rt_i)));
    hazard_c_o = rs_haz || rt_haz;
  end

  // Clear applied before set so a collision leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: input slot S1 holds the raw fetch word, out slot S2 holds the
// decoded instruction presented to execute; RAW hazards stall S1.
module decode_stage
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   command,
  output logic              hold,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [RIDX_W-1:0] wb_rd,
  decode_if.master          out_if
);

  fetch_word_t s1_q, s1_d;
  dec_instr_t  s2_q, s2_d;
  logic        s2_valid_q, s2_valid_d;

  dec_instr_t  dec;
  logic        use_rs;
  logic        use_rt;
  logic        hazard;
  logic        s1_move;
  logic        in_ready;
  logic        sb_set;
  logic        out_ready;

  assign out_ready = out_if.out_ready;

  // Field extraction and classification of the word waiting in S1.
  always_comb begin
    dec       = '0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    dec.pc    = s1_q.pc;
    dec.op    = s1_q.cmd[31:26];
    dec.rs    = s1_q.cmd[25:21];
    dec.rt    = s1_q.cmd[20:16];
    dec.shamt = s1_q.cmd[10:6];
    dec.funct = s1_q.cmd[5:0];
    dec.imm   = {{16{s1_q.cmd[15]}}, s1_q.cmd[15:0]};
    dec.cls   = CLS_ILLEGAL;
    if (s1_q.cmd == '0) begin
      dec.cls = CLS_NOP;
    end else begin
      case (s1_q.cmd[31:26])
        OP_RTYPE: begin
          dec.cls = CLS_RTYPE;
          dec.rd  = s1_q.cmd[15:11];
          use_rs  = 1'b1;
          use_rt  = 1'b1;
        end
        OP_J, OP_JAL, OP_BC: begin
          dec.cls = CLS_JUMP;
          dec.imm = {4'b0000, s1_q.cmd[25:0], 2'b00};
          if (s1_q.cmd[31:26] == OP_JAL) dec.rd = RIDX_W'(LINK_REG);
        end
        OP_BEQ, OP_BNE: begin
          dec.cls = CLS_BRANCH;
          use_rs  = 1'b1;
          use_rt  = 1'b1;
        end
        OP_LW: begin
          dec.cls = CLS_LOAD;
          dec.rd  = s1_q.cmd[20:16];
          use_rs  = 1'b1;
        end
        OP_SW: begin
          dec.cls = CLS_STORE;
          use_rs  = 1'b1;
          use_rt  = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          dec.cls = CLS_IALU;
          dec.rd  = s1_q.cmd[20:16];
          dec.imm = {16'h0000, s1_q.cmd[15:0]};
          use_rs  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  decode_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (sb_set),
    .set_idx_i  (s2_q.rd),
    .clr_en_i   (wb_valid),
    .clr_idx_i  (wb_rd),
    .rs_i       (dec.rs),
    .rt_i       (dec.rt),
    .use_rs_i   (use_rs),
    .use_rt_i   (use_rt),
    .pend_en_i  (s2_valid_q && !out_ready),
    .pend_rd_i  (s2_q.rd),
    .hazard_c_o (hazard)
  );

  // Slot handshake; flush discards both slots and the incoming word.
  always_comb begin
    s1_move    = s1_q.valid && !hazard && (!s2_valid_q || out_ready);
    in_ready   = !s1_q.valid || s1_move;
    hold       = !in_ready;
    sb_set     = s2_valid_q && out_ready && !flush && (s2_q.rd != '0);
    s1_d       = s1_q;
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_d.valid = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (enable && in_ready) begin
        s1_d.valid = 1'b1;
        s1_d.pc    = pc;
        s1_d.cmd   = command;
      end else if (s1_move) begin
        s1_d.valid = 1'b0;
      end
      if (s1_move) begin
        s2_d       = dec;
        s2_valid_d = 1'b1;
      end else if (out_ready) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_if.out_valid = s2_valid_q;
  assign out_if.out_pc    = s2_q.pc;
  assign out_if.out_class = s2_q.cls;
  assign out_if.out_rs    = s2_q.rs;
  assign out_if.out_rt    = s2_q.rt;
  assign out_if.out_rd    = s2_q.rd;
  assign out_if.out_imm   = s2_q.imm;
  assign out_if.out_shamt = s2_q.shamt;
  assign out_if.out_funct = s2_q.funct;
  assign out_if.out_op    = s2_q.op;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenario tasks plus a queue-based
// scoreboard that checks every instruction accepted by execute.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] pc;
  logic [31:0] command;
  logic        hold;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  decode_if dif ();

  decode_stage dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .pc       (pc),
    .command  (command),
    .hold     (hold),
    .flush    (flush),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .out_if   (dif)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [5:0]  op;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference decoder written from the instruction encoding table.
  function automatic exp_t model(input logic [31:0] p, input logic [31:0] c);
    exp_t e;
    logic [5:0] o;
    o       = c[31:26];
    e.pc    = p;
    e.op    = o;
    e.rs    = c[25:21];
    e.rt    = c[20:16];
    e.shamt = c[10:6];
    e.funct = c[5:0];
    e.rd    = 5'd0;
    e.imm   = {{16{c[15]}}, c[15:0]};
    e.cls   = 3'd7;
    if (c == 32'h0) e.cls = 3'd0;
    else if (o == 6'h00) begin e.cls = 3'd1; e.rd = c[15:11]; end
    else if (o == 6'h02 || o == 6'h03 || o == 6'h32) begin
      e.cls = 3'd6;
      e.imm = {4'h0, c[25:0], 2'b00};
      if (o == 6'h03) e.rd = 5'd31;
    end
    else if (o == 6'h04 || o == 6'h05) e.cls = 3'd5;
    else if (o == 6'h23) begin e.cls = 3'd3; e.rd = c[20:16]; end
    else if (o == 6'h2B) e.cls = 3'd4;
    else if (o == 6'h0C || o == 6'h0D || o == 6'h0E) begin
      e.cls = 3'd2; e.rd = c[20:16]; e.imm = {16'h0, c[15:0]};
    end
    return e;
  endfunction

  // Scoreboard: push on acceptance into S1, pop and compare on issue.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (dif.out_valid && dif.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h with no instruction pending", dif.out_pc);
        end else begin
          e = q.pop_front();
          if ({dif.out_pc, dif.out_class, dif.out_rs, dif.out_rt, dif.out_rd, dif.out_imm,
               dif.out_shamt, dif.out_funct, dif.out_op} !== e) begin
            errors++;
            $display("FAIL sb_issue: got pc=%h cls=%0d rs=%0d rt=%0d rd=%0d imm=%h sh=%0d fn=%h op=%h expected %h",
                     dif.out_pc, dif.out_class, dif.out_rs, dif.out_rt, dif.out_rd, dif.out_imm,
                     dif.out_shamt, dif.out_funct, dif.out_op, e);
          end
        end
      end
      if (enable && !hold) q.push_back(model(pc, command));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] p, input logic [31:0] c);
    int n;
    pc = p; command = c; enable = 1'b1;
    n = 0;
    @(negedge clk);
    while (hold && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL send_timeout: hold still %b after 50 cycles, required 0", hold); end
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wb_clear(input logic [4:0] r);
    wb_valid = 1'b1; wb_rd = r;
    tick(1);
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; pc = '0; command = '0; flush = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; dif.out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", dif.out_valid); end
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b want 0", hold); end
    checks++; if (dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL rst_busy: got %h want 0", dut.u_sb.busy_q); end
    checks++; if (dif.out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", dif.out_pc); end
    checks++; if (dif.out_imm !== 32'h0 || dif.out_class !== 3'd0) begin
      errors++; $display("FAIL rst_fields: got imm=%h cls=%0d want 0", dif.out_imm, dif.out_class); end
  endtask

  task automatic test_latency();
    enable = 1'b1; pc = 32'h0; command = 32'h012A4020;
    tick(1);
    enable = 1'b0;
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL lat_n1: got valid=%b want 0", dif.out_valid); end
    tick(1);
    checks++; if (dif.out_valid !== 1'b1) begin errors++; $display("FAIL lat_n2: got valid=%b want 1", dif.out_valid); end
    checks++; if (dif.out_class !== 3'd1 || dif.out_rs !== 5'd9 || dif.out_rt !== 5'd10 || dif.out_rd !== 5'd8) begin
      errors++; $display("FAIL lat_fields: got cls=%0d rs=%0d rt=%0d rd=%0d want 1/9/10/8",
                         dif.out_class, dif.out_rs, dif.out_rt, dif.out_rd); end
    tick(1);
    checks++; if (dut.u_sb.busy_q[8] !== 1'b1) begin errors++; $display("FAIL lat_busy8: got %b want 1", dut.u_sb.busy_q[8]); end
    wb_clear(5'd8);
    checks++; if (dut.u_sb.busy_q[8] !== 1'b0) begin errors++; $display("FAIL lat_clr8: got %b want 0", dut.u_sb.busy_q[8]); end
  endtask

  task automatic test_raw();
    send(32'h10, 32'h012A4020);
    tick(3);
    send(32'h14, 32'h01095822);
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL raw_hold: got %b want 1", hold); end
    tick(2);
    checks++; if (hold !== 1'b1 || dif.out_valid !== 1'b0) begin
      errors++; $display("FAIL raw_stall: got hold=%b valid=%b want 1/0", hold, dif.out_valid); end
    wb_valid = 1'b1; wb_rd = 5'd8;
    #1;
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL raw_bypass: got hold=%b want 0", hold); end
    tick(1);
    wb_valid = 1'b0;
    checks++; if (dif.out_valid !== 1'b1 || dif.out_rd !== 5'd11 || dif.out_rs !== 5'd8) begin
      errors++; $display("FAIL raw_issue: got valid=%b rd=%0d rs=%0d want 1/11/8", dif.out_valid, dif.out_rd, dif.out_rs); end
    tick(1);
    checks++; if (dut.u_sb.busy_q[11] !== 1'b1 || dut.u_sb.busy_q[8] !== 1'b0) begin
      errors++; $display("FAIL raw_busy: got b11=%b b8=%b want 1/0", dut.u_sb.busy_q[11], dut.u_sb.busy_q[8]); end
    wb_clear(5'd11);
  endtask

  task automatic test_imm();
    send(32'h20, 32'h8CC5FFFC);
    tick(1);
    checks++; if (dif.out_class !== 3'd3 || dif.out_rd !== 5'd5 || dif.out_imm !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL imm_lw: got cls=%0d rd=%0d imm=%h want 3/5/fffffffc", dif.out_class, dif.out_rd, dif.out_imm); end
    send(32'h24, 32'h34058000);
    tick(1);
    checks++; if (dif.out_class !== 3'd2 || dif.out_rd !== 5'd5 || dif.out_imm !== 32'h00008000) begin
      errors++; $display("FAIL imm_ori: got cls=%0d rd=%0d imm=%h want 2/5/00008000", dif.out_class, dif.out_rd, dif.out_imm); end
    tick(1);
    wb_clear(5'd5);
  endtask

  task automatic test_stall();
    dif.out_ready = 1'b0;
    send(32'h100, 32'h00430820);
    send(32'h104, 32'h00A62020);
    for (int i = 0; i < 3; i++) begin
      checks++; if (hold !== 1'b1 || dif.out_valid !== 1'b1 || dif.out_pc !== 32'h100 || dif.out_rd !== 5'd1) begin
        errors++; $display("FAIL stall_hold%0d: got hold=%b valid=%b pc=%h rd=%0d want 1/1/100/1",
                           i, hold, dif.out_valid, dif.out_pc, dif.out_rd); end
      checks++; if (dut.u_sb.busy_q[1] !== 1'b0) begin errors++; $display("FAIL stall_noset%0d: got %b want 0", i, dut.u_sb.busy_q[1]); end
      tick(1);
    end
    dif.out_ready = 1'b1;
    #1;
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL stall_release: got hold=%b want 0", hold); end
    tick(1);
    checks++; if (dif.out_pc !== 32'h104 || dif.out_rd !== 5'd4 || dut.u_sb.busy_q[1] !== 1'b1) begin
      errors++; $display("FAIL stall_next: got pc=%h rd=%0d b1=%b want 104/4/1", dif.out_pc, dif.out_rd, dut.u_sb.busy_q[1]); end
    tick(1);
    checks++; if (dut.u_sb.busy_q[4] !== 1'b1) begin errors++; $display("FAIL stall_b4: got %b want 1", dut.u_sb.busy_q[4]); end
    wb_clear(5'd1);
    wb_clear(5'd4);
  endtask

  task automatic test_flush();
    send(32'h200, 32'h0000A020);
    tick(3);
    checks++; if (dut.u_sb.busy_q !== 32'h0010_0000) begin errors++; $display("FAIL flush_pre: got %h want 00100000", dut.u_sb.busy_q); end
    dif.out_ready = 1'b0;
    send(32'h204, 32'h00223820);
    send(32'h208, 32'h00226020);
    checks++; if (hold !== 1'b1 || dif.out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_full: got hold=%b valid=%b want 1/1", hold, dif.out_valid); end
    flush = 1'b1; enable = 1'b1; pc = 32'h20C; command = 32'h00226820; dif.out_ready = 1'b1;
    tick(1);
    flush = 1'b0; enable = 1'b0;
    checks++; if (dif.out_valid !== 1'b0 || hold !== 1'b0) begin
      errors++; $display("FAIL flush_empty: got valid=%b hold=%b want 0/0", dif.out_valid, hold); end
    checks++; if (dut.u_sb.busy_q !== 32'h0010_0000) begin errors++; $display("FAIL flush_busy: got %h want 00100000", dut.u_sb.busy_q); end
    tick(2);
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got valid=%b want 0", dif.out_valid); end
    wb_clear(5'd20);
  endtask

  task automatic test_jal_set_wins();
    send(32'h300, 32'h0C000040);
    tick(1);
    checks++; if (dif.out_class !== 3'd6 || dif.out_rd !== 5'd31 || dif.out_imm !== 32'h00000100) begin
      errors++; $display("FAIL jal_fields: got cls=%0d rd=%0d imm=%h want 6/31/00000100", dif.out_class, dif.out_rd, dif.out_imm); end
    wb_valid = 1'b1; wb_rd = 5'd31;
    tick(1);
    wb_valid = 1'b0;
    checks++; if (dut.u_sb.busy_q[31] !== 1'b1) begin errors++; $display("FAIL jal_setwins: got %b want 1", dut.u_sb.busy_q[31]); end
    wb_clear(5'd31);
    checks++; if (dut.u_sb.busy_q[31] !== 1'b0) begin errors++; $display("FAIL jal_clear: got %b want 0", dut.u_sb.busy_q[31]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [9];
    int n;
    words = '{32'h10220003, 32'h1422FFFF, 32'hAC220008, 32'h00000000, 32'hFC000000,
              32'h0BFFFFFF, 32'hC8000010, 32'h380EFFFF, 32'h300F8001};
    for (int i = 0; i < 9; i++) send(32'h400 + 32'(i * 4), words[i]);
    n = 0;
    while (q.size() != 0 && n < 20) begin tick(1); n++; end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending want 0", q.size()); end
  endtask

  task automatic test_mid_reset();
    dif.out_ready = 1'b0;
    send(32'h500, 32'h00430820);
    send(32'h504, 32'h00A62020);
    rst = 1'b1; enable = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3;
    tick(1);
    rst = 1'b0; enable = 1'b0; wb_valid = 1'b0;
    checks++; if (dif.out_valid !== 1'b0 || hold !== 1'b0) begin
      errors++; $display("FAIL mrst_slots: got valid=%b hold=%b want 0/0", dif.out_valid, hold); end
    checks++; if (dut.u_sb.busy_q !== 32'h0) begin errors++; $display("FAIL mrst_busy: got %h want 0", dut.u_sb.busy_q); end
    checks++; if (dif.out_pc !== 32'h0 || dif.out_rd !== 5'd0) begin
      errors++; $display("FAIL mrst_fields: got pc=%h rd=%0d want 0/0", dif.out_pc, dif.out_rd); end
    dif.out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_raw();
    test_imm();
    test_stall();
    test_flush();
    test_jal_set_wins();
    test_back_to_back();
    test_mid_reset();
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Stage directly downstream of instruction fetch.
- Accepts one {pc, command} word per handshake from fetch and extracts the fields of the MIPS-style encoding.
- Tracks pending register writes in a 32-entry scoreboard, holds on RAW hazards and issues decoded instructions to execute through a registered output slot.
- Drops all in-flight work when execute redirects the PC.

Parameters:
- NREG, 32, number of architectural registers (scoreboard width).
- LINK_REG, 31, destination written by JAL.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  fetch has a valid word this cycle (driven by fetch done).
- pc  in  32  address of command.
- command  in  32  instruction word.
- hold  out  1  fetch must not advance; equals ~in_ready.
- flush  in  1  execute redirect (same cycle as fetch pcenable).
- out_ready  in  1  execute accepts out slot.
- out_valid  out  1  out slot holds a decoded instruction.
- out_pc  out  32  pc of issued instruction.
- out_class  out  3  0 NOP, 1 RTYPE, 2 IALU, 3 LOAD, 4 STORE, 5 BRANCH, 6 JUMP, 7 ILLEGAL.
- out_rs, out_rt, out_rd  out  5 each  source and destination indices; out_rd=0 means no write.
- out_imm  out  32  imm16 sign-extended (ANDI/ORI/XORI zero-extended); for J/JAL/BC {4'b0, imm26, 2'b00}.
- out_shamt  out  5  command[10:6].
- out_funct  out  6  command[5:0].
- out_op  out  6  command[31:26].
- wb_valid  in  1  writeback retiring a register write.
- wb_rd  in  5  register retired.

Behaviour:
- Reset: out_valid=0, slot valid=0, scoreboard=0, hold=0; all other outputs 0.
- Two registers in series:
  - S1 (input slot): raw pc/command.
  - S2 (out slot): decoded fields, which drive the out_* ports directly.
- Minimum latency: enable in cycle N gives out_valid in cycle N+2.
- in_ready = ~S1.valid | s1_move. S1 loads when enable & in_ready.
- s1_move = S1.valid & ~hazard & (~S2.valid | out_ready).
- Source use by class:
  - RTYPE reads rs and rt.
  - IALU and LOAD read rs.
  - STORE and BRANCH (BEQ 000100, BNE 000101) read rs and rt.
  - JUMP (J 000010, JAL 000011, BC 110010) reads none.
- hazard: a used source s != 0 satisfies (busy[s] & ~(wb_valid & wb_rd==s)) | (S2.valid & S2.rd==s & ~out_ready). The same-cycle writeback bypass is mandatory.
- Destination by class:
  - RTYPE: rd.
  - IALU and LOAD: rt.
  - JAL: LINK_REG.
  - All others: 0.
  - command==0 decodes as NOP with rd=0.
  - Unknown opcode decodes as ILLEGAL with rd=0 and is forwarded without trapping.
- Scoreboard:
  - Set busy[S2.rd] when out_valid & out_ready & S2.rd!=0.
  - Clear busy[wb_rd] when wb_valid.
  - Set and clear of the same index in the same cycle: set wins.
  - busy[0] is always 0.
- S2 retires on out_ready; it reloads from S1 in the same cycle if s1_move.
- flush:
  - Clears S1.valid and S2.valid next cycle.
  - Suppresses the scoreboard set for that cycle.
  - Ignores enable in the same cycle (flush wins).
  - Scoreboard entries already set remain until their writeback.
- rst asserted mid-operation: all state returns to reset values next cycle regardless of other inputs.
- S2 outputs stay stable while out_valid & ~out_ready.

Decomposition:
- Package decode_pkg holds:
  - Opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BC, OP_LW, OP_SW, OP_ANDI, OP_ORI, OP_XORI).
  - The 3-bit class enum.
  - A decoded-instruction struct used for the S2 register.
- Sub-module decode_scoreboard contains the busy vector and the set/clear/bypass hazard query. All field decode stays combinational in the parent.

Test Plan:
- Reset, then enable with command=0x012A4020 (add r8,r9,r10), pc=0x0 and out_ready=1 -> out_valid exactly 2 cycles later with class RTYPE, rs=9, rt=10, rd=8; busy[8] set the following cycle.
- Issue add r8 then sub r11,r8,r9 with no writeback -> second instruction held in S1, hold=1; assert wb_valid with wb_rd=8 -> sub issues in the same cycle's s1_move and hold drops.
- lw r5,-4(r6) (0x8CC5FFFC) -> class LOAD, rd=5, imm=0xFFFFFFFC; ori r5,r0,0x8000 -> imm=0x00008000.
- out_ready=0 for 3 cycles with S1 and S2 both full -> hold=1 and out_* stable; no scoreboard set until the accepting cycle.
- flush asserted together with enable, with S1 and S2 full -> both slots empty next cycle, incoming word dropped, busy unchanged.
- jal 0x100 (0x0C000040) issued while wb_valid with wb_rd=31 in the same cycle -> busy[31]=1 afterwards (set wins); out_imm=0x00000100.
